// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit.
// This file holds the funct codes, the FSM states and the default latencies.
package md_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // {loen,hien} command decode
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_MTHI  = 2'b01;
    localparam logic [1:0] CMD_MTLO  = 2'b10;
    localparam logic [1:0] CMD_START = 2'b11;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_divider.sv
// Combinational 32-bit signed/unsigned divide and remainder.
// A zero divisor yields quo=all-ones and rem=dividend. The signed overflow case is also handled here.
module md_divider
    import md_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        uq    = 32'd0;
        ur    = 32'd0;
        if (mag_b != 32'd0) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        quo = 32'd0;
        rem = 32'd0;
        if (b == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = a;
        end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            // The quotient truncates toward zero. The remainder takes the dividend's sign.
            quo = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
            rem = neg_a ? (32'd0 - ur) : ur;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at start and are held pending until the latency counter expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loen,
    input  logic        hien,
    input  logic [1:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // The state is kept as a named enum so that checkers can bind to md_unit.state.
    md_state_t   state;
    logic [CW-1:0] counter;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic [1:0]  cmd;
    logic        sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    assign cmd     = {loen, hien};
    assign sgn     = ~funct[0];
    assign ext_a   = {{32{sgn & rs_val[31]}}, rs_val};
    assign ext_b   = {{32{sgn & rt_val[31]}}, rt_val};
    assign product = ext_a * ext_b;

    md_divider u_div (
        .a         (rs_val),
        .b         (rt_val),
        .is_signed (sgn),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // Handshake: a command is accepted only at an edge where busy is low.
    // A command presented while busy is high is dropped, because the stall logic
    // upstream is expected to hold the pipeline until busy falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd == CMD_START) begin
                        busy <= 1'b1;
                        if (funct[1]) begin
                            state   <= DIV;
                            counter <= CW'(DIV_CYCLES);
                            pend_hi <= div_rem;
                            pend_lo <= div_quo;
                        end else begin
                            state   <= MUL;
                            counter <= CW'(MULT_CYCLES);
                            pend_hi <= product[63:32];
                            pend_lo <= product[31:0];
                        end
                    end else if (cmd == CMD_MTHI) begin
                        hi <= rs_val;
                    end else if (cmd == CMD_MTLO) begin
                        lo <= rs_val;
                    end
                end
                MUL, DIV: begin
                    if (counter == CW'(1)) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                        hi      <= pend_hi;
                        lo      <= pend_lo;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed and random checks of md_unit against a plain-arithmetic reference model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst_n;
    logic        loen;
    logic        hien;
    logic [1:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run;
    int tests_failed;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .loen   (loen),
        .hien   (hien),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: this computes the architectural result from the arithmetic rules.
    task automatic model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!f[1]) begin
            if (f[0]) up = {32'd0, a} * {32'd0, b};
            else begin
                sp = sa * sb;
                up = sp;
            end
            eh = up[63:32];
            el = up[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else if (f[0]) begin
            eh = a % b;
            el = a / b;
        end else begin
            sp = sa % sb;
            eh = sp[31:0];
            sp = sa / sb;
            el = sp[31:0];
        end
    endtask

    // Start an operation. Check busy and stale HI/LO every busy cycle, then check the result.
    // inject_mthi issues an mthi in the middle of the op, which must be ignored.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit inject_mthi);
        int n;
        n = f[1] ? DC : MC;
        @(negedge clk);
        loen = 1'b1; hien = 1'b1; funct = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        loen = 1'b0; hien = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k < n; k++) begin
            if (inject_mthi && k == 2) begin
                hien = 1'b1; rs_val = 32'd9;
            end
            @(posedge clk); #1;
            hien = 1'b0;
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_stale_hi"}, hi, hi_m);
            check({tag, "_stale_lo"}, lo, lo_m);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        hi_m = eh;
        lo_m = el;
    endtask

    task automatic move_to(input string tag, input bit to_hi, input logic [31:0] v);
        @(negedge clk);
        loen = ~to_hi; hien = to_hi; rs_val = v;
        @(posedge clk); #1;
        loen = 1'b0; hien = 1'b0;
        if (to_hi) hi_m = v; else lo_m = v;
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [1:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        tests_run = 0; tests_failed = 0;
        loen = 0; hien = 0; funct = 0; rs_val = 0; rt_val = 0;
        hi_m = 0; lo_m = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", 2'b11, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        move_to("mtlo5", 1'b0, 32'd5);
        move_to("mthi_a", 1'b1, 32'hA5A5_0001);
        run_op("mult_mthi_ign", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 5) == 0) begin
                move_to("rand_mv", 1'($urandom_range(0, 1)), $urandom);
            end
            model(rf, ra, rb, eh, el);
            run_op("rand_op", rf, ra, rb, eh, el, 1'b0);
        end

        // An asynchronous reset in the middle of a divide must discard the pending result at once.
        move_to("pre_rst", 1'b1, 32'h1357_2468);
        @(negedge clk);
        loen = 1'b1; hien = 1'b1; funct = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        loen = 1'b0; hien = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        hi_m = 0; lo_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DC + 2) begin
            @(posedge clk); #1;
            check("postrst_idle_lo", lo, 32'd0);
        end
        run_op("postrst_mult", 2'b01, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
